// File: rtl/frame_queue_reader.sv
// Frame token queue reader: pops 17-bit framing tokens through a 2-entry skid
// buffer, parses frame/row structure and emits a valid/ready pixel stream.
//
// state        | meaning
// S_WAIT_FRAME | waiting for a frame start token
// S_WAIT_ROW   | inside a frame, waiting for a row start or frame end
// S_PIXELS     | inside a row, emitting pixels until x reaches FRAME_WIDTH
module frame_queue_reader #(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        queue_empty,
  input  logic [16:0] queue_data,
  output logic        queue_rd_en,
  output logic        queue_rd_clk,
  input  logic        pix_ready,
  output logic        pix_valid,
  output logic [15:0] pix_data,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        pix_eof,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic [4:0]  error_flags,
  input  logic        error_clear
);

  localparam logic [10:0] W   = 11'(FRAME_WIDTH);
  localparam logic [10:0] WM1 = 11'(FRAME_WIDTH - 1);
  localparam logic [10:0] H   = 11'(FRAME_HEIGHT);
  localparam logic [10:0] HM1 = 11'(FRAME_HEIGHT - 1);

  localparam logic [16:0] TOK_FRAME = 17'h10000;
  localparam logic [16:0] TOK_ROW   = 17'h10001;
  localparam logic [16:0] TOK_END   = 17'h1FFFF;

  typedef enum logic [1:0] {S_WAIT_FRAME, S_WAIT_ROW, S_PIXELS} state_t;

  state_t      st_q;
  logic [10:0] x_q, y_q;
  logic        rd_pend_q;
  logic [1:0]  cnt_q, cnt_d;
  logic [16:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic        pix_valid_q, pix_sof_q, pix_eol_q, pix_eof_q, frame_done_q;
  logic [15:0] pix_data_q, frame_count_q;
  logic [10:0] pix_x_q, pix_y_q;
  logic [4:0]  err_q;

  logic        head_vld, out_free, take;
  logic [16:0] head;

  assign queue_rd_clk = clk;
  // Reads are held off during reset so no token is lost to the in-flight discard.
  assign queue_rd_en  = !reset && !queue_empty && ({1'b0, cnt_q} + {2'b00, rd_pend_q}) < 3'd2;

  // The head token bypasses the buffer when it is empty, sustaining 1 token/clk.
  assign head_vld = (cnt_q != 2'd0) || rd_pend_q;
  assign head     = (cnt_q != 2'd0) ? buf0_q : queue_data;
  assign out_free = !pix_valid_q || pix_ready;
  assign take     = head_vld && (head[16] || st_q != S_PIXELS || out_free);

  always_comb begin
    cnt_d  = cnt_q;
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    unique case ({take, rd_pend_q})
      2'b01: begin
        if (cnt_q == 2'd0) begin
          buf0_d = queue_data;
          cnt_d  = 2'd1;
        end else begin
          buf1_d = queue_data;
          cnt_d  = 2'd2;
        end
      end
      2'b10: begin
        buf0_d = buf1_q;
        cnt_d  = 2'(cnt_q - 2'd1);
      end
      2'b11: if (cnt_q != 2'd0) buf0_d = queue_data;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q          <= S_WAIT_FRAME;
      x_q           <= '0;
      y_q           <= '0;
      rd_pend_q     <= 1'b0;
      cnt_q         <= '0;
      buf0_q        <= '0;
      buf1_q        <= '0;
      pix_valid_q   <= 1'b0;
      pix_data_q    <= '0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_sof_q     <= 1'b0;
      pix_eol_q     <= 1'b0;
      pix_eof_q     <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      err_q         <= '0;
    end else begin
      rd_pend_q    <= queue_rd_en;
      cnt_q        <= cnt_d;
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
      frame_done_q <= 1'b0;
      if (pix_valid_q && pix_ready) pix_valid_q <= 1'b0;
      // Later bit writes below override this, so a new error beats a clear.
      if (error_clear) err_q <= '0;

      if (take) begin
        if (!head[16]) begin
          unique case (st_q)
            S_WAIT_ROW: begin
              if (x_q == W) err_q[2] <= 1'b1;
              else          err_q[0] <= 1'b1;
            end
            S_PIXELS: begin
              pix_valid_q <= 1'b1;
              pix_data_q  <= head[15:0];
              pix_x_q     <= x_q;
              pix_y_q     <= y_q;
              pix_sof_q   <= (x_q == '0) && (y_q == '0);
              pix_eol_q   <= (x_q == WM1);
              pix_eof_q   <= (x_q == WM1) && (y_q == HM1);
              x_q         <= x_q + 11'd1;
              if (x_q == WM1) begin
                y_q  <= y_q + 11'd1;
                st_q <= S_WAIT_ROW;
              end
            end
            default: err_q[0] <= 1'b1;
          endcase
        end else if (head == TOK_FRAME) begin
          if (!(st_q == S_WAIT_FRAME || (st_q == S_WAIT_ROW && (y_q == '0 || y_q == H))))
            err_q[3] <= 1'b1;
          x_q  <= '0;
          y_q  <= '0;
          st_q <= S_WAIT_ROW;
        end else if (head == TOK_ROW) begin
          if (st_q == S_PIXELS) err_q[1] <= 1'b1;
          if (st_q != S_WAIT_FRAME) begin
            x_q  <= '0;
            st_q <= S_PIXELS;
          end
        end else if (head == TOK_END) begin
          if (st_q == S_WAIT_ROW && y_q == H) begin
            frame_done_q  <= 1'b1;
            frame_count_q <= frame_count_q + 16'd1;
          end else if (st_q != S_WAIT_FRAME) begin
            err_q[3] <= 1'b1;
          end
          st_q <= S_WAIT_FRAME;
        end else begin
          err_q[4] <= 1'b1;
        end
      end
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_data    = pix_data_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_sof     = pix_sof_q;
  assign pix_eol     = pix_eol_q;
  assign pix_eof     = pix_eof_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign error_flags = err_q;

endmodule

// File: tb/tb_frame_queue_reader.sv
// Directed bench for frame_queue_reader with a 4x2 frame: a token-level model
// predicts the pixel stream, errors and frame counts; a FIFO model feeds the DUT.
module tb_frame_queue_reader;
  localparam int W = 4;
  localparam int H = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        queue_empty = 1'b1;
  logic [16:0] queue_data = '0;
  logic        queue_rd_en, queue_rd_clk;
  logic        pix_ready = 1'b1;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic [10:0] pix_x, pix_y;
  logic        pix_sof, pix_eol, pix_eof;
  logic        frame_done;
  logic [15:0] frame_count;
  logic [4:0]  error_flags;
  logic        error_clear = 1'b0;

  frame_queue_reader #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .queue_empty(queue_empty), .queue_data(queue_data),
    .queue_rd_en(queue_rd_en), .queue_rd_clk(queue_rd_clk), .pix_ready(pix_ready),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof), .frame_done(frame_done),
    .frame_count(frame_count), .error_flags(error_flags), .error_clear(error_clear)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Token-level model of the framing protocol.
  logic [16:0] fifo[$];
  logic [40:0] exp_q[$];
  int          m_st = 0;  // 0 outside frame, 1 between rows, 2 in row
  int          m_x = 0, m_y = 0, m_count = 0, m_done = 0;
  logic [4:0]  m_err = '0;
  int          done_cnt = 0, px_seen = 0;
  bit          ready_toggle = 0, rand_empty = 0;

  task automatic send(input logic [16:0] t);
    if (!t[16]) begin
      if (m_st == 2) begin
        exp_q.push_back({t[15:0], 11'(m_x), 11'(m_y), m_x == 0 && m_y == 0,
                         m_x == W-1, m_x == W-1 && m_y == H-1});
        m_x++;
        if (m_x == W) begin m_y++; m_st = 1; end
      end else if (m_st == 1 && m_x == W) m_err[2] = 1'b1;
      else m_err[0] = 1'b1;
    end else if (t == 17'h10000) begin
      if (!(m_st == 0 || (m_st == 1 && (m_y == 0 || m_y == H)))) m_err[3] = 1'b1;
      m_x = 0; m_y = 0; m_st = 1;
    end else if (t == 17'h10001) begin
      if (m_st == 2) m_err[1] = 1'b1;
      if (m_st != 0) begin m_x = 0; m_st = 2; end
    end else if (t == 17'h1FFFF) begin
      if (m_st == 1 && m_y == H) begin m_count++; m_done++; end
      else if (m_st != 0) m_err[3] = 1'b1;
      m_st = 0;
    end else m_err[4] = 1'b1;
    fifo.push_back(t);
  endtask

  task automatic send_row(input int n, input logic [15:0] base);
    send(17'h10001);
    for (int i = 0; i < n; i++) send({1'b0, 16'(base + 16'(i))});
  endtask

  task automatic send_frame(input logic [15:0] base);
    send(17'h10000);
    send_row(W, base);
    send_row(W, base + 16'(W));
    send(17'h1FFFF);
  endtask

  task automatic drain_and_check(input string nm);
    bit ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (fifo.size() == 0 && exp_q.size() == 0) begin ok = 1; break; end
    end
    chk({nm, "_drain"}, 64'(ok), 64'd1);
    repeat (6) @(negedge clk);
    chk({nm, "_err"}, 64'(error_flags), 64'(m_err));
    chk({nm, "_fcount"}, 64'(frame_count), 64'(m_count));
    chk({nm, "_done"}, 64'(done_cnt), 64'(m_done));
  endtask

  task automatic clear_errors();
    @(negedge clk) error_clear = 1'b1;
    @(negedge clk) error_clear = 1'b0;
    m_err = '0;
    chk("err_clear", 64'(error_flags), 64'd0);
  endtask

  // FIFO model with one-cycle read latency.
  always @(posedge clk) begin
    if (queue_rd_en) begin
      n_total++;
      if (queue_empty || fifo.size() == 0)
        $display("FAIL rd_while_empty: got rd_en=1 expected rd_en=0");
      else begin
        n_pass++;
        queue_data <= fifo.pop_front();
      end
    end
  end

  // Output compare and input drive, away from the active edge.
  logic [40:0] prev_px = '0;
  bit          prev_v = 0, prev_r = 0;
  always @(negedge clk) begin
    logic [40:0] cur;
    cur = {pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof};
    if (frame_done) done_cnt++;
    if (prev_v && !prev_r) chk("hold", {22'd0, pix_valid, cur}, {22'd0, 1'b1, prev_px});
    if (pix_valid) begin
      if (exp_q.size() == 0) chk("unexpected_pixel", 64'(cur), 64'd0 - 64'd1);
      else chk("pixel", 64'(cur), 64'(exp_q[0]));
    end
    pix_ready   = ready_toggle ? ~pix_ready : 1'b1;
    queue_empty = (fifo.size() == 0) || (rand_empty && $urandom_range(0, 2) == 0);
    if (pix_valid && pix_ready) begin
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      px_seen++;
    end
    prev_v = pix_valid; prev_r = pix_ready; prev_px = cur;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_state", {pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof,
                        frame_done, frame_count, error_flags, queue_rd_en}, 64'd0);
    reset = 1'b0;

    // Clean frame, full throughput.
    send(17'h10000);
    send_row(W, 16'h0000);
    send_row(W, 16'h0004);
    send(17'h1FFFF);
    drain_and_check("t1");
    chk("t1_px_lit", 64'(px_seen), 64'd8);
    chk("t1_fc_lit", 64'(frame_count), 64'd1);
    chk("t1_err_lit", 64'(error_flags), 64'd0);
    chk("t1_done_lit", 64'(done_cnt), 64'd1);

    // Same frame with back-pressure and a stuttering FIFO.
    ready_toggle = 1; rand_empty = 1;
    send_frame(16'h0000);
    drain_and_check("t2");
    ready_toggle = 0; rand_empty = 0;
    chk("t2_px_lit", 64'(px_seen), 64'd16);
    chk("t2_fc_lit", 64'(frame_count), 64'd2);

    // Pixel outside any frame.
    send(17'h01234);
    drain_and_check("t3");
    chk("t3_err_lit", 64'(error_flags), 64'h01);
    clear_errors();

    // Short row, then premature frame end.
    send(17'h10000);
    send_row(3, 16'h0100);
    send_row(4, 16'h0200);
    send(17'h1FFFF);
    drain_and_check("t4");
    chk("t4_err_lit", 64'(error_flags), 64'h0A);
    chk("t4_done_lit", 64'(done_cnt), 64'd2);
    clear_errors();

    // Long row and an unknown control code mid-frame.
    send(17'h10000);
    send_row(5, 16'h0300);
    send(17'h10005);
    send_row(W, 16'h0400);
    send(17'h1FFFF);
    drain_and_check("t5");
    chk("t5_err_lit", 64'(error_flags), 64'h14);
    chk("t5_fc_lit", 64'(frame_count), 64'd3);

    // Reset mid-row, then stray pixels and a full frame.
    send(17'h10000);
    send_row(2, 16'h0500);
    drain_and_check("t6a");
    @(negedge clk) reset = 1'b1;
    m_st = 0; m_x = 0; m_y = 0; m_err = '0; m_count = 0;
    send(17'h00AAA);
    repeat (2) @(negedge clk);
    chk("t6_reset_outputs", {pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof,
                             frame_done, frame_count, error_flags, queue_rd_en}, 64'd0);
    reset = 1'b0;
    send(17'h00BBB);
    send_frame(16'h0600);
    drain_and_check("t6");
    chk("t6_err_lit", 64'(error_flags), 64'h01);
    chk("t6_fc_lit", 64'(frame_count), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/frame_queue_reader.md
Name: frame_queue_reader

Overview:
- Read side of the 17-bit frame token queue filled by the debug pattern generator and the camera path.
- Pops tokens from the FIFO and parses the framing protocol:
  - 17'h10000 = frame start
  - 17'h10001 = row start
  - {1'b0, rgb565} = pixel
  - 17'h1FFFF = frame end
- Emits a valid/ready pixel stream with x/y coordinates and SOF/EOL/EOF flags.
- Detects and resynchronises on protocol violations before pixels reach the display/PSRAM writer.

Parameters:
FRAME_WIDTH, 640, pixels per row
FRAME_HEIGHT, 480, rows per frame

Ports:
clk  input  1  system clock; also FIFO read clock
reset  input  1  synchronous, active-high reset
queue_empty  input  1  FIFO empty flag
queue_data  input  17  FIFO read data, valid one cycle after an accepted read
queue_rd_en  output  1  FIFO read enable
queue_rd_clk  output  1  tied to clk
pix_ready  input  1  downstream accepts pixel
pix_valid  output  1  pixel output valid
pix_data  output  16  RGB565 pixel
pix_x  output  11  column of pix_data
pix_y  output  11  row of pix_data
pix_sof  output  1  first pixel of frame (x=0, y=0)
pix_eol  output  1  last pixel of row (x=FRAME_WIDTH-1)
pix_eof  output  1  last pixel of frame (x=W-1, y=H-1)
frame_done  output  1  one-cycle pulse when a valid 17'h1FFFF is accepted
frame_count  output  16  count of completed frames, wraps at 16'hFFFF
error_flags  output  5  sticky: [0] pixel outside frame, [1] short row, [2] long row, [3] short frame, [4] unknown control code
error_clear  input  1  clears error_flags, synchronous

Behaviour:
- Reset (clk edge with reset=1):
  - All outputs 0, state WAIT_FRAME, counters 0, output buffer empty.
  - Any in-flight FIFO read is discarded.
  - Reset mid-frame requires a new 17'h10000 before pixels are emitted again.
- FIFO read:
  - queue_rd_en = !queue_empty && (buffered + in-flight tokens) < 2.
  - Read latency is 1 cycle; a 2-entry skid buffer absorbs it, so a continuous stream with pix_ready=1 sustains 1 pixel/clk.
  - queue_rd_en is never asserted while queue_empty=1.
- Output handshake:
  - Pixel transfers when pix_valid && pix_ready.
  - pix_data, pix_x, pix_y and the flags hold stable while pix_valid && !pix_ready.
  - Control tokens consume no output cycle.
- Parser states (evaluated once per token, in order):
  - WAIT_FRAME:
    - 10000 -> y=0, WAIT_ROW.
    - Pixel -> drop, set err[0].
    - 10001 or 1FFFF -> drop, no error.
  - WAIT_ROW:
    - 10001 -> x=0, PIXELS.
    - Pixel -> drop, err[0].
    - 1FFFF: if y==FRAME_HEIGHT -> frame_done, frame_count+1, WAIT_FRAME; else err[3], WAIT_FRAME.
  - PIXELS:
    - Pixel with x<FRAME_WIDTH -> emit, x+1. On x==W-1 emit with eol, y+1, then WAIT_ROW.
    - 10001 before the row completes -> err[1], x=0, stay in PIXELS with the same y.
    - 1FFFF before the row completes -> err[3], WAIT_FRAME.
  - Any state:
    - 10000 -> restarts the frame (y=0, WAIT_ROW). Sets err[3] unless in WAIT_FRAME, or in WAIT_ROW with y==0 or y==H.
    - Control word with bit16=1 other than 10000/10001/1FFFF -> drop, err[4], state unchanged.
- Long rows:
  - Pixels received in WAIT_ROW after a completed row (x==W, before the next 10001 or 1FFFF) -> drop, err[2].
  - err[0] is not also raised for these pixels.
- Flags:
  - pix_sof when x==0 && y==0.
  - pix_eol when x==W-1.
  - pix_eof when x==W-1 && y==H-1.
  - All flags are registered together with pix_data.
- Errors: error_flags are sticky. If error_clear and a new error occur in the same cycle, the new error wins (bit remains set).
- Widths: counters are 11 bits; FRAME_WIDTH and FRAME_HEIGHT must be at most 2047.

Test Plan:
- W=4, H=2. Queue holds 10000, 10001, 0000..0003, 10001, 0004..0007, 1FFFF with pix_ready=1 -> 8 pixels on consecutive cycles:
  - x: 0,1,2,3,0,1,2,3; y: 0,0,0,0,1,1,1,1.
  - sof on pixel 0; eol on pixels 3 and 7; eof on pixel 7.
  - frame_done one pulse, frame_count=1, error_flags=0.
- Same stream, pix_ready toggled 1010… and queue_empty randomly asserted -> identical pixel sequence, with no drop or duplicate. queue_rd_en is never high while queue_empty=1.
- Pixel 0x1234 before any 10000 -> no pix_valid, error_flags=5'b00001. Pulse error_clear -> error_flags=0.
- 10000, 10001, 3 pixels, 10001, 4 pixels, 1FFFF -> err[1] set. Second row emitted with y=0. The 1FFFF then sets err[3], with no frame_done.
- 10000, 10001, 5 pixels -> 4 emitted, 5th dropped, err[2]=1. Token 17'h10005 -> err[4]=1, parsing unaffected.
- Reset asserted mid-row -> all outputs 0 the next cycle. Subsequent pixels are dropped (err[0]) until a 10000; the next full frame parses correctly.
